// File: rtl/mem_addr_gen_pkg.sv
// mem_addr_gen_pkg: shared types for the tile address generator.
// FSM states, default widths and the latched tile descriptor.
// Optional macro: MEM_ADDR_GEN_COL_MAJOR_EN adds the col_major field.
package mem_addr_gen_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DIM_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] base;
    logic [DIM_W_DEF-1:0]  rows;
    logic [DIM_W_DEF-1:0]  cols;
    logic [ADDR_W_DEF-1:0] stride;
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
    logic                  col_major;
`endif
  } desc_t;

endpackage

// File: rtl/agen_wrap_counter.sv
// agen_wrap_counter: counter that returns to 0 after reaching max.
// Ports: clk, rst, clear, enable, max in; count, at_max, wrap out.
module agen_wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         wrap
);

  logic [W-1:0] r_count;

  assign count  = r_count;
  assign at_max = (r_count == max);
  assign wrap   = enable & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (clear || wrap)
      r_count <= '0;
    else if (enable)
      r_count <= r_count + W'(1);
  end

endmodule

// File: rtl/mem_addr_gen.sv
// mem_addr_gen: 2-D tile address generator, one address per handshake.
// In: clk, rst, start, base, rows, cols, stride, addr_ready
//     (+ col_major when MEM_ADDR_GEN_COL_MAJOR_EN is defined).
// Out: busy, addr_valid, addr, last, done.
module mem_addr_gen
  import mem_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [ADDR_W-1:0] stride,
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
  input  logic              col_major,
`endif
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              done
);

  state_t r_state, w_state_nxt;
  desc_t  r_desc;
  logic [ADDR_W-1:0] r_addr;

  logic w_zero, w_go, w_hs, w_cm;
  logic w_tile_end, w_inner_wrap;
  logic w_row_en, w_col_en;
  logic w_row_at_max, w_col_at_max;
  logic w_row_wrap, w_col_wrap;
  logic [DIM_W-1:0]  w_row_max, w_col_max;
  logic [DIM_W-1:0]  w_row_cnt, w_col_cnt;
  logic [ADDR_W-1:0] w_inner_step, w_outer_step;
  logic [ADDR_W-1:0] w_next_line;

`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
  assign w_cm = r_desc.col_major;
`else
  assign w_cm = 1'b0;
`endif

  assign w_zero = (rows == '0) | (cols == '0);
  assign w_go   = (r_state == IDLE) & start & ~w_zero;
  assign w_hs   = (r_state == RUN) & addr_ready;

  assign w_row_max = r_desc.rows - DIM_W'(1);
  assign w_col_max = r_desc.cols - DIM_W'(1);

  // Inner counter steps on every handshake, outer only at inner max.
  assign w_col_en = w_cm ? (w_hs & w_row_at_max) : w_hs;
  assign w_row_en = w_cm ? w_hs : (w_hs & w_col_at_max);

  assign w_inner_wrap = w_cm ? w_row_wrap : w_col_wrap;
  // Both counters wrap together only on the final handshake.
  assign w_tile_end   = w_row_wrap & w_col_wrap;

  assign w_inner_step = w_cm ? r_desc.stride : ADDR_W'(1);
  assign w_outer_step = w_cm ? ADDR_W'(1) : r_desc.stride;
  assign w_next_line  = r_desc.base + w_outer_step;

  agen_wrap_counter #(.W(DIM_W)) u_row (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_go),
    .enable (w_row_en),
    .max    (w_row_max),
    .count  (w_row_cnt),
    .at_max (w_row_at_max),
    .wrap   (w_row_wrap)
  );

  agen_wrap_counter #(.W(DIM_W)) u_col (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_go),
    .enable (w_col_en),
    .max    (w_col_max),
    .count  (w_col_cnt),
    .at_max (w_col_at_max),
    .wrap   (w_col_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = w_zero ? DONE : RUN;
      RUN:     if (w_tile_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_desc.base doubles as the running line base (row or column start).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desc <= '0;
      r_addr <= '0;
    end else if (w_go) begin
      r_desc.base   <= base;
      r_desc.rows   <= rows;
      r_desc.cols   <= cols;
      r_desc.stride <= stride;
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
      r_desc.col_major <= col_major;
`endif
      r_addr <= base;
    end else if (w_hs) begin
      if (w_inner_wrap) begin
        r_desc.base <= w_next_line;
        r_addr      <= w_next_line;
      end else begin
        r_addr <= r_addr + w_inner_step;
      end
    end
  end

  assign busy       = (r_state == RUN) | (r_state == DONE);
  assign addr_valid = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign addr       = r_addr;
  assign last       = (r_state == RUN)
                    & (w_row_cnt == w_row_max)
                    & (w_col_cnt == w_col_max);

endmodule

// File: tb/tb_mem_addr_gen.sv
// tb_mem_addr_gen: self-checking bench for mem_addr_gen.
// Table vectors, reset corner cases and randomized tiles vs a model.
module tb_mem_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] rows = '0;
  logic [15:0] cols = '0;
  logic [15:0] stride = '0;
  logic        cm_in = 1'b0;
  logic        addr_ready = 1'b0;
  logic        busy, addr_valid, last, done;
  logic [15:0] addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .rows       (rows),
    .cols       (cols),
    .stride     (stride),
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
    .col_major  (cm_in),
`endif
    .busy       (busy),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .last       (last),
    .done       (done)
  );

  typedef struct {
    logic [15:0] base;
    logic [15:0] rows;
    logic [15:0] cols;
    logic [15:0] stride;
    bit          cm;
    int          mode;
    bit          restart;
    int          exp_hs;
    logic [15:0] exp_last;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Address of the idx-th element in traversal order.
  function automatic logic [15:0] exp_addr(
    input logic [15:0] b, input logic [15:0] s,
    input logic [15:0] r, input logic [15:0] c,
    input bit cmv, input int idx);
    int ro, co;
    if (!cmv) begin
      ro = idx / int'(c);
      co = idx % int'(c);
    end else begin
      co = idx / int'(r);
      ro = idx % int'(r);
    end
    return 16'(int'(b) + ro * int'(s) + co);
  endfunction

  // Called at a negedge with the DUT idle; starts in this cycle.
  task automatic run_tile(
    input logic [15:0] b, input logic [15:0] r,
    input logic [15:0] c, input logic [15:0] s,
    input bit cmv, input int mode, input bit restart,
    output int hs, output logic [15:0] last_a);
    int n, cyc, idx, bound;
    bit rd;
    n = int'(r) * int'(c);
    bound = 8 * n + 20;
    hs = 0;
    idx = 0;
    last_a = '0;
    base = b; rows = r; cols = c; stride = s; cm_in = cmv;
    start = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base = 16'($urandom);
    stride = 16'($urandom);
    cyc = 1;
    while (idx < n && cyc < bound) begin
      chk("valid", addr_valid, 1);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      chk("addr", addr, exp_addr(b, s, r, c, cmv, idx));
      chk("last", last, (idx == n - 1));
      case (mode)
        0: rd = 1'b1;
        1: rd = ((cyc - 1) % 3 == 0);
        default: rd = 1'($urandom_range(0, 1));
      endcase
      addr_ready = rd;
      if (restart && cyc == 2) begin
        start = 1'b1;
        base = 16'h1234; rows = 16'd7; cols = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (rd) begin
        idx++;
        hs++;
        last_a = addr;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < n) chk("timeout", idx, n);
    start = 1'b0;
    addr_ready = 1'($urandom_range(0, 1));
    chk("done", done, 1);
    chk("valid_done", addr_valid, 0);
    chk("busy_done", busy, 1);
    if (mode == 0) chk("done_cycle", cyc, n + 1);
    @(negedge clk);
    chk("done_clr", done, 0);
    chk("busy_idle", busy, 0);
    chk("valid_idle", addr_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vq[$];
    int hs;
    logic [15:0] la;

    vq.push_back('{16'h0100, 16'd2, 16'd3, 16'h0010, 1'b0, 0, 1'b0,
                   6, 16'h0112});
    vq.push_back('{16'h0100, 16'd2, 16'd3, 16'h0010, 1'b0, 1, 1'b0,
                   6, 16'h0112});
    vq.push_back('{16'h0200, 16'd0, 16'd5, 16'h0010, 1'b0, 0, 1'b0,
                   0, 16'h0000});
    vq.push_back('{16'h0300, 16'd3, 16'd0, 16'h0010, 1'b0, 0, 1'b0,
                   0, 16'h0000});
    vq.push_back('{16'hFFFE, 16'd1, 16'd4, 16'h0005, 1'b0, 0, 1'b1,
                   4, 16'h0001});
    vq.push_back('{16'h0042, 16'd1, 16'd1, 16'h7777, 1'b0, 2, 1'b0,
                   1, 16'h0042});
    vq.push_back('{16'hFFF0, 16'd3, 16'd2, 16'h0010, 1'b0, 2, 1'b0,
                   6, 16'h0011});
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
    vq.push_back('{16'h0100, 16'd2, 16'd3, 16'h0010, 1'b1, 0, 1'b0,
                   6, 16'h0112});
    vq.push_back('{16'h0100, 16'd2, 16'd3, 16'h0010, 1'b1, 1, 1'b0,
                   6, 16'h0112});
`endif

    #1;
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vq[i]) begin
      run_tile(vq[i].base, vq[i].rows, vq[i].cols, vq[i].stride,
               vq[i].cm, vq[i].mode, vq[i].restart, hs, la);
      chk("vec_hs", hs, vq[i].exp_hs);
      chk("vec_last_addr", la, vq[i].exp_last);
    end

    // Reset after three of six handshakes.
    base = 16'h0100; rows = 16'd2; cols = 16'd3; stride = 16'h0010;
    cm_in = 1'b0;
    start = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_addr", addr, 16'h0110);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", addr_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_last", last, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", addr_valid, 0);
    end
    run_tile(16'h0100, 16'd2, 16'd3, 16'h0010, 1'b0, 0, 1'b0, hs, la);
    chk("rerun_hs", hs, 6);
    chk("rerun_last_addr", la, 16'h0112);

    // Randomized tiles.
    for (int k = 0; k < 20; k++) begin
      logic [15:0] rb, rs, rr, rc;
      bit rcm;
      rb = 16'($urandom);
      rs = 16'($urandom);
      rr = 16'($urandom_range(0, 4));
      rc = 16'($urandom_range(1, 5));
`ifdef MEM_ADDR_GEN_COL_MAJOR_EN
      rcm = 1'($urandom_range(0, 1));
`else
      rcm = 1'b0;
`endif
      run_tile(rb, rr, rc, rs, rcm, 2, 1'b0, hs, la);
      chk("rand_hs", hs, int'(rr) * int'(rc));
      if (rr != 0)
        chk("rand_last_addr", la,
            exp_addr(rb, rs, rr, rc, rcm, int'(rr) * int'(rc) - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_addr_gen.md
# mem_addr_gen

Tile address generator for the memory controller. On a start pulse it latches a 2-D tile descriptor (base, rows, cols, stride) and emits one SRAM word address per accepted handshake. The traversal uses two nested wrap counters (inner column, outer row). Addresses feed the SRAM read port and the systolic-array operand loader downstream.

## Interface
- ADDR_W, 16, address width; all address arithmetic is modulo 2^ADDR_W
- DIM_W, 16, width of the row/column extent fields
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  ADDR_W  tile start address; latched on accepted start
- rows  in  DIM_W  outer extent; latched on accepted start
- cols  in  DIM_W  inner extent; latched on accepted start
- stride  in  ADDR_W  address distance between rows; latched on accepted start
- busy  out  1  high in RUN and DONE
- addr_valid  out  1  addr holds a valid address
- addr_ready  in  1  consumer accepts addr this cycle
- addr  out  ADDR_W  current address
- last  out  1  qualifies the final address of the tile; meaningful only with addr_valid
- done  out  1  one-cycle pulse after the tile completes

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE → RUN:** start=1 with rows≠0 and cols≠0. Latch the descriptor, clear both counters, set row_base=base.
- **IDLE → DONE:** start=1 with rows=0 or cols=0. No address is emitted.
- **RUN:**
  - addr_valid=1 and addr = row_base + col.
  - A handshake is addr_valid & addr_ready. On each handshake, col increments.
  - When col = cols−1 and a handshake occurs, col wraps to 0, row increments, and row_base += stride.
  - last = (row = rows−1) & (col = cols−1).
  - A handshake with last=1 moves to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE.
- Without a handshake, addr, last, and the counters hold stable. The consumer may stall indefinitely.
- start while busy is ignored; descriptor inputs are don't-care outside the accepting cycle.
- Total handshakes per tile = rows×cols. Counters are DIM_W wide; extents up to 2^DIM_W−1 are legal.
- Address overflow wraps silently modulo 2^ADDR_W.

## Timing
- Reset values: state=IDLE, busy=0, addr_valid=0, addr=0, last=0, done=0. Counters and row_base are 0.
- Reset asserted mid-tile aborts immediately. done is not pulsed and no further addresses are emitted.
- Start-to-first-valid latency is 1 cycle: start in cycle N gives addr_valid=1 with addr=base in cycle N+1.
- Sustained throughput is 1 address/cycle with addr_ready held high.
- With addr_ready held high, the final handshake occurs in cycle N+rows×cols and done is high in cycle N+rows×cols+1. The earliest next start is accepted in cycle N+rows×cols+2.
- Zero-extent start in cycle N gives done in N+1 and addr_valid never asserts.
- addr_valid must not depend combinationally on addr_ready. All outputs are registered or decoded from registered state only.

## Configuration
- **MEM_ADDR_GEN_COL_MAJOR_EN defined:**
  - Adds input port col_major (1 bit), latched on accepted start.
  - col_major=1 selects column-major traversal: the row counter is inner and the column counter is outer.
  - Each handshake adds stride to addr. At inner wrap, col_base += 1 and addr restarts at col_base.
  - last = (col = cols−1) & (row = rows−1).
  - Handshake count and all timing are unchanged.
- **Not defined:** port col_major is absent and traversal is row-major only.

## Structure
- Package mem_addr_gen_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default ADDR_W/DIM_W constants;
  - a packed descriptor struct (base, rows, cols, stride, and col_major when enabled).
- Sub-module agen_wrap_counter, instantiated twice. Parameter W. Ports: clk, rst, clear, enable, max, count, at_max, wrap.
  - wrap = enable & at_max.
  - count returns to 0 on wrap or clear.
  - Reset is asynchronous active-high to 0.

## Test plan
- **Basic row-major:** base=0x100, rows=2, cols=3, stride=0x10, addr_ready=1 → addresses 0x100,0x101,0x102,0x110,0x111,0x112 on consecutive cycles. last only on 0x112; done one cycle later.
- **Backpressure:** same descriptor, addr_ready toggled 1,0,0,1,… → no address skipped or repeated; addr and last stable while stalled. Exactly 6 handshakes.
- **Zero extent:** start with rows=0, cols=5 → addr_valid never asserts; done pulses in the cycle after start.
- **Wrap-around and ignored restart:**
  - ADDR_W=16, base=0xFFFE, rows=1, cols=4 → addresses 0xFFFE,0xFFFF,0x0000,0x0001.
  - A second start during the tile is ignored.
- **Reset mid-tile:** assert rst after 3 of 6 handshakes → all outputs 0 immediately, no done. A fresh start then begins again at base.
- **Column-major (MEM_ADDR_GEN_COL_MAJOR_EN only):** col_major=1, base=0x100, rows=2, cols=3, stride=0x10 → addresses 0x100,0x110,0x101,0x111,0x102,0x112 with last on 0x112.
